dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the array; it SHALL be a power of two and at least 4.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from the accept cycle to the response cycle; it SHALL be at least 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits, of type mem_size_t: 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-justified.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle response pulse.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: load data, right-justified and zero-extended.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the request was misaligned, out of range or had a reserved size.

Function
REQ-014 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_we, req_size, req_addr and req_wdata SHALL be latched on that edge.
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-016 Transitions SHALL be:
- IDLE to BUSY on accept, loading a countdown with LATENCY-2;
- IDLE to RESP on accept when LATENCY=1;
- BUSY to RESP when the count reaches 0, otherwise decrement;
- RESP to IDLE unconditionally.
REQ-017 For an accept in cycle c, rsp_valid SHALL be 1 in cycle c+LATENCY only, and req_ready SHALL return to 1 in cycle c+LATENCY+1; there SHALL be no back-pressure on the response.
REQ-018 The array access (write commit and read sample) SHALL occur on the edge entering RESP.
REQ-019 A request SHALL be an error if any of the following holds:
- req_size=11;
- half size with addr[0]=1;
- word size with addr[1:0]!=0;
- addr[31:2] >= DEPTH_WORDS.
REQ-020 An error request SHALL leave the array unmodified and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-021 A store SHALL write only the addressed lanes, leaving all other bytes unchanged:
- byte: lane addr[1:0] = wdata[7:0];
- half: lanes addr[1]*2 and addr[1]*2+1 = wdata[15:0];
- word: all lanes.
REQ-022 A load SHALL return the addressed lanes shifted down by 8*addr[1:0], with bits above the access size forced to 0; sign extension is the mem stage's job.
REQ-023 A store response SHALL have rsp_rdata=0 and rsp_err=0 when legal.
REQ-024 rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-025 A load issued after a store to the same word SHALL return the stored data; transactions are strictly serial.
REQ-026 req_valid while req_ready=0 SHALL be ignored, and the requester SHALL hold the request until it is accepted.

Reset
REQ-027 While reset=1 on an edge, the state SHALL go to IDLE and the counter SHALL clear.
REQ-028 During and immediately after reset, rsp_valid=0, rsp_err=0 and rsp_rdata=0; req_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-029 Reset on the edge that would enter RESP SHALL suppress the write commit and the response; an in-flight transaction SHALL be dropped.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 mem_size_t and the FSM state enum (dmem_state_t) SHALL live in rv32_pkg.
REQ-032 The storage SHALL be one sub-module, dmem_sram: single-port, 32-bit, with 4 byte-enables, synchronous write and synchronous read in the same edge, with read-before-write on the same port.
REQ-033 Lane steering, byte-enable generation and error decode SHALL be combinational logic in dmem_responder.

Verification (LATENCY=2, DEPTH_WORDS=1024)
REQ-034 Word store: 0xDEADBEEF to 0x10, then word load from 0x10 -> rsp_rdata=0xDEADBEEF and rsp_err=0; rsp_valid exactly 2 cycles after each accept.
REQ-035 Lanes: byte store 0xA5 to 0x13, then word load from 0x10 -> 0xA5ADBEEF; half load from 0x12 -> 0x0000A5AD; byte load from 0x11 -> 0x000000BE.
REQ-036 Errors: word load from 0x6, half store to 0x11, and word load from 0x1000 -> each gives rsp_err=1 and rsp_rdata=0; a word load from 0x10 afterwards is unchanged.
REQ-037 Handshake: req_valid held high continuously -> req_ready pattern 1,0,0,1 per transaction (one accept per 3 cycles); no duplicate accepts.
REQ-038 Reset mid-op: word store 0x12345678 to 0x20, reset asserted in the cycle after accept -> no rsp_valid; a later load from 0x20 returns the prior value.
REQ-039 LATENCY=1 build: rsp_valid in the cycle after accept, with back-to-back accepts every 2 cycles.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 memory-access types: access size encoding and the data-memory FSM states.
package rv32_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        RESP = ST_RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a load/store unit (master) and the data-memory responder (slave).
interface dmem_responder_if;
    import rv32_pkg::*;

    // A request transfers on a rising edge where req_valid && req_ready; the master holds
    // req_we/req_size/req_addr/req_wdata stable until then. The response is a single-cycle
    // rsp_valid pulse that the master must take (no rsp_ready); rsp_* are 0 otherwise.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_size_t   req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_sram.sv
// Single-port 32-bit SRAM with per-byte write enables; read and write share one edge,
// and the read returns the word as it was before that edge's write.
module dmem_sram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                for (int i = 0; i < 4; i++) begin
                    if (be_i[i]) begin
                        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, answers LATENCY cycles later with
// a one-cycle pulse, and does lane steering, byte-enable generation and error decode itself.
module dmem_responder
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,  // power of two, >= 4
    parameter int unsigned LATENCY     = 2      // >= 1
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus,
    output dmem_state_t     state_o
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int unsigned CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        we_q;
    mem_size_t   size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        enter_resp;
    logic        rsp_fire;

    logic        cur_we;
    mem_size_t   cur_size;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic        size_err;
    logic        out_of_range;
    logic        cur_err;
    logic [3:0]  be;
    logic [31:0] lane_wdata;

    logic        sram_en;
    logic [31:0] sram_rdata;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    // Outside IDLE the latched request drives everything; in IDLE the live request does,
    // which is what a LATENCY=1 build needs on its accept edge.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = bus.req_we;
            cur_size  = bus.req_size;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
        end else begin
            cur_we    = we_q;
            cur_size  = size_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    always_comb begin
        size_err = 1'b0;
        case (cur_size)
            SIZE_HALF: size_err = cur_addr[0];
            SIZE_WORD: size_err = (cur_addr[1:0] != 2'b00);
            SIZE_RSVD: size_err = 1'b1;
            default:   size_err = 1'b0;
        endcase
    end

    assign out_of_range = ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign cur_err      = size_err || out_of_range;

    always_comb begin
        be         = 4'b0000;
        lane_wdata = cur_wdata;
        case (cur_size)
            SIZE_BYTE: begin
                be         = 4'b0001 << cur_addr[1:0];
                lane_wdata = {4{cur_wdata[7:0]}};
            end
            SIZE_HALF: begin
                be         = 4'b0011 << {cur_addr[1], 1'b0};
                lane_wdata = {2{cur_wdata[15:0]}};
            end
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(CNT_INIT);
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // A reset on the entry edge kills the access, so an in-flight store never commits.
    assign sram_en = enter_resp && !reset && !cur_err;

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk     (clk),
        .en_i    (sram_en),
        .we_i    (cur_we),
        .be_i    (be),
        .addr_i  (cur_addr[AW+1:2]),
        .wdata_i (lane_wdata),
        .rdata_o (sram_rdata)
    );

    assign shifted = sram_rdata >> {cur_addr[1:0], 3'b000};

    always_comb begin
        case (cur_size)
            SIZE_BYTE: load_data = {24'h000000, shifted[7:0]};
            SIZE_HALF: load_data = {16'h0000, shifted[15:0]};
            default:   load_data = shifted;
        endcase
    end

    assign rsp_fire      = (state_q == RESP) && !reset;
    assign bus.rsp_valid = rsp_fire;
    assign bus.rsp_err   = rsp_fire && cur_err;
    assign bus.rsp_rdata = (rsp_fire && !cur_err && !cur_we) ? load_data : 32'h0;

    assign state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=1 instance, each checked every cycle
// against a byte-array model of the responder, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_dmem_responder;
    import rv32_pkg::*;

    localparam int unsigned DEPTH  = 1024;
    localparam int          REGION = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_state_t st0, st1;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .state_o(st0)
    );
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .state_o(st1)
    );

    // ---------------- reference model ----------------
    logic [31:0] mem_m   [2][REGION];
    logic        m_busy  [2];
    int          m_due   [2];
    logic        m_exec  [2];
    logic        m_we    [2];
    logic [1:0]  m_size  [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_rd    [2];
    logic        m_err   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_exec(input int k);
        int          nb;
        int          off;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] rd;
        a   = m_addr[k];
        off = int'(a[1:0]);
        nb  = (m_size[k] == 2'b00) ? 1 : (m_size[k] == 2'b01) ? 2 : 4;
        m_err[k] = (m_size[k] == 2'b11) || (nb == 2 && a[0]) || (nb == 4 && off != 0)
                   || ((a >> 2) >= DEPTH);
        m_rd[k] = 32'h0;
        if (!m_err[k]) begin
            w = a >> 2;
            if (m_we[k]) begin
                for (int b = 0; b < nb; b++) mem_m[k][w][8*(off+b) +: 8] = m_wdata[k][8*b +: 8];
            end else begin
                rd = mem_m[k][w] >> (8 * off);
                if (nb < 4) rd = rd & ((32'h1 << (8 * nb)) - 32'h1);
                m_rd[k] = rd;
            end
        end
    endtask

    task automatic mon_step(input int k, input int lat, input logic rv, input logic rr,
                            input logic rsv, input logic [31:0] rd, input logic re,
                            input logic we, input logic [1:0] sz,
                            input logic [31:0] ad, input logic [31:0] wd);
        logic  exp_ready;
        logic  exp_valid;
        string p;
        p = $sformatf("d%0d", k);
        exp_ready = !reset && !m_busy[k];
        exp_valid = m_busy[k] && m_exec[k] && (cyc == m_due[k]) && !reset;
        chk({p, "_req_ready"}, 32'(rr), 32'(exp_ready));
        chk({p, "_rsp_valid"}, 32'(rsv), 32'(exp_valid));
        chk({p, "_rsp_rdata"}, rd, exp_valid ? m_rd[k] : 32'h0);
        chk({p, "_rsp_err"}, 32'(re), 32'(exp_valid && m_err[k]));
        if (m_busy[k] && (cyc == m_due[k] || reset)) m_busy[k] = 1'b0;
        if (exp_ready && rv) begin
            m_busy[k]  = 1'b1;
            m_due[k]   = cyc + lat;
            m_exec[k]  = 1'b0;
            m_we[k]    = we;
            m_size[k]  = sz;
            m_addr[k]  = ad;
            m_wdata[k] = wd;
        end
        // The array is touched on the edge ending the cycle before the response.
        if (m_busy[k] && !m_exec[k] && !reset && cyc == m_due[k] - 1) begin
            m_exec[k] = 1'b1;
            model_exec(k);
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon_step(0, 2, bus0.req_valid, bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata,
                     bus0.rsp_err, bus0.req_we, bus0.req_size, bus0.req_addr, bus0.req_wdata);
            mon_step(1, 1, bus1.req_valid, bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata,
                     bus1.rsp_err, bus1.req_we, bus1.req_size, bus1.req_addr, bus1.req_wdata);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_req(input int k, input logic we, input logic [1:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd);
        if (k == 0) begin
            bus0.req_we = we; bus0.req_size = mem_size_t'(sz);
            bus0.req_addr = ad; bus0.req_wdata = wd;
        end else begin
            bus1.req_we = we; bus1.req_size = mem_size_t'(sz);
            bus1.req_addr = ad; bus1.req_wdata = wd;
        end
    endtask

    task automatic rand_req(output logic we, output logic [1:0] sz,
                            output logic [31:0] ad, output logic [31:0] wd);
        int r;
        r  = $urandom_range(0, 9);
        we = 1'($urandom_range(0, 1));
        sz = (r == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        ad = 32'($urandom_range(0, REGION * 4 - 1));
        if (r == 1) begin
            ad = ad + 32'h1000;
        end else if (r >= 4) begin
            if (sz == 2'b01) ad[0] = 1'b0;
            if (sz == 2'b10) ad[1:0] = 2'b00;
        end
        wd = $urandom;
    endtask

    // Single request on bus0, called and returning just after a rising edge.
    task automatic txn0(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
        int acc_cyc;
        bit got;
        set_req(0, we, sz, ad, wd);
        bus0.req_valid = 1'b1;
        got = 1'b0;
        acc_cyc = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus0.req_ready) begin got = 1'b1; acc_cyc = cyc; end
            @(posedge clk); #1;
        end
        bus0.req_valid = 1'b0;
        chk("txn0_accepted", 32'(got), 32'd1);
        rd = 32'h0; er = 1'b0; lat = -1; got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus0.rsp_valid) begin
                got = 1'b1; rd = bus0.rsp_rdata; er = bus0.rsp_err; lat = cyc - acc_cyc;
            end
            @(posedge clk); #1;
        end
        chk("txn0_responded", 32'(got), 32'd1);
    endtask

    // req_valid held high for n accepts; init mode fills the model region with known words.
    task automatic stream(input int k, input int n, input int lat, input bit init);
        logic        we;
        logic [1:0]  sz;
        logic [31:0] ad, wd;
        int          acc, last, budget;
        bit          rdy, need;
        acc = 0; last = -1; budget = 0; need = 1'b1;
        if (k == 0) bus0.req_valid = 1'b1; else bus1.req_valid = 1'b1;
        while (acc < n && budget < n * (lat + 1) * 2 + 20) begin
            if (need) begin
                if (init) begin
                    we = 1'b1; sz = 2'b10; ad = 32'(acc * 4); wd = 32'hC0DE_0000 | 32'(acc);
                end else begin
                    rand_req(we, sz, ad, wd);
                end
                set_req(k, we, sz, ad, wd);
                need = 1'b0;
            end
            @(negedge clk);
            rdy = (k == 0) ? bus0.req_ready : bus1.req_ready;
            if (rdy) begin
                if (last >= 0) chk($sformatf("d%0d_accept_spacing", k), 32'(cyc - last), 32'(lat + 1));
                last = cyc;
                acc++;
                need = 1'b1;
            end
            @(posedge clk); #1;
            budget++;
        end
        if (k == 0) bus0.req_valid = 1'b0; else bus1.req_valid = 1'b0;
        chk($sformatf("d%0d_stream_accepts", k), 32'(acc), 32'(n));
        repeat (lat + 2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random scenarios ----------------
    initial begin
        logic [31:0] rd, ad, wd;
        logic        er, we;
        logic [1:0]  sz;
        int          lat, seen;

        m_busy[0] = 1'b0; m_busy[1] = 1'b0;
        m_exec[0] = 1'b0; m_exec[1] = 1'b0;
        bus0.req_valid = 1'b0; bus1.req_valid = 1'b0;
        set_req(0, 1'b0, 2'b10, 32'h0, 32'h0);
        set_req(1, 1'b0, 2'b10, 32'h0, 32'h0);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(bus0.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", bus0.rsp_rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 32'(bus0.req_ready), 32'd1);
        chk("post_reset_state", 32'(st0), 32'(IDLE));
        chk("post_reset_ready_lat1", 32'(bus1.req_ready), 32'd1);
        @(posedge clk); #1;

        stream(0, REGION, 2, 1'b1);
        stream(1, REGION, 1, 1'b1);

        txn0(1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        chk("word_store_lat", 32'(lat), 32'd2);
        chk("word_store_rdata", rd, 32'h0);
        chk("word_store_err", 32'(er), 32'd0);
        txn0(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
        chk("word_load_lat", 32'(lat), 32'd2);
        chk("word_load_rdata", rd, 32'hDEAD_BEEF);
        chk("word_load_err", 32'(er), 32'd0);

        txn0(1'b1, 2'b00, 32'h13, 32'h0000_00A5, rd, er, lat);
        txn0(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
        chk("lane_word_load", rd, 32'hA5AD_BEEF);
        txn0(1'b0, 2'b01, 32'h12, 32'h0, rd, er, lat);
        chk("lane_half_load", rd, 32'h0000_A5AD);
        txn0(1'b0, 2'b00, 32'h11, 32'h0, rd, er, lat);
        chk("lane_byte_load", rd, 32'h0000_00BE);

        txn0(1'b0, 2'b10, 32'h6, 32'h0, rd, er, lat);
        chk("err_misaligned_word_err", 32'(er), 32'd1);
        chk("err_misaligned_word_rdata", rd, 32'h0);
        txn0(1'b1, 2'b01, 32'h11, 32'hFFFF_FFFF, rd, er, lat);
        chk("err_misaligned_half_err", 32'(er), 32'd1);
        txn0(1'b0, 2'b10, 32'h1000, 32'h0, rd, er, lat);
        chk("err_out_of_range_err", 32'(er), 32'd1);
        chk("err_out_of_range_rdata", rd, 32'h0);
        txn0(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
        chk("err_left_array_intact", rd, 32'hA5AD_BEEF);

        // Reset one cycle after accept: the store must vanish without a response.
        set_req(0, 1'b1, 2'b10, 32'h20, 32'h1234_5678);
        bus0.req_valid = 1'b1;
        @(negedge clk);
        chk("midop_accept_ready", 32'(bus0.req_ready), 32'd1);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus0.rsp_valid) seen++;
        end
        @(posedge clk); #1;
        chk("midop_no_rsp", 32'(seen), 32'd0);
        txn0(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
        chk("midop_prior_value", rd, 32'hC0DE_0008);

        stream(0, 60, 2, 1'b0);
        stream(1, 60, 1, 1'b0);
        repeat (20) begin
            rand_req(we, sz, ad, wd);
            txn0(we, sz, ad, wd, rd, er, lat);
            chk("rand_lat", 32'(lat), 32'd2);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
